// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared constants, state type and index-width helper for the memory bus arbiter
package mem_bus_arbiter_pkg;
  localparam int NUM_ARB_MASTERS = 2;
  localparam int IFU = 0;
  localparam int LSU = 1;
  localparam int ARB_TIMEOUT = 255;
  localparam int ARB_CNT_W = 8;
  typedef enum logic [1:0] {IDLE, RD, WR} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: request/response handshake bundle between bus masters and the arbiter
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N = NUM_ARB_MASTERS
);
  localparam int IW = idx_w(N);
  logic [N-1:0]  req_rd;
  logic [N-1:0]  req_wr;
  logic          rsp_rvalid;
  logic [N-1:0]  m_rready;
  logic          rsp_bvalid;
  logic [N-1:0]  m_bready;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          grant_wr;
  logic          busy;
  logic          timeout_err;
  modport master (
    output req_rd, req_wr, rsp_rvalid, m_rready, rsp_bvalid, m_bready,
    input  grant, grant_id, grant_wr, busy, timeout_err
  );
  modport slave (
    input  req_rd, req_wr, rsp_rvalid, m_rready, rsp_bvalid, m_bready,
    output grant, grant_id, grant_wr, busy, timeout_err
  );
endinterface

// File: rtl/mem_bus_arbiter_arb_rr_pick.sv
// arb_rr_pick: first set request scanning upward from i_ptr with wrap (rotate, priority-encode, un-rotate)
module arb_rr_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N = NUM_ARB_MASTERS,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_pick
);
  localparam logic [IW:0] NW = (IW + 1)'(N);
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_idx;
  logic [IW:0]    w_sum;
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];
  always_comb begin
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) if (w_rot[k]) w_idx = IW'(k);
  end
  assign w_sum   = {1'b0, w_idx} + {1'b0, i_ptr};
  assign o_found = |i_req;
  assign o_pick  = (w_sum >= NW) ? IW'(w_sum - NW) : IW'(w_sum);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the shared memory bus, one transaction per grant, with watchdog
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_ARB_MASTERS,
  parameter int TIMEOUT     = ARB_TIMEOUT,
  parameter int CNT_W       = ARB_CNT_W
) (
  input logic clk,
  input logic rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int IW = idx_w(NUM_MASTERS);
  arb_state_e             r_state, w_state;
  logic [NUM_MASTERS-1:0] r_grant, w_grant, w_req;
  logic [IW-1:0]          r_id, w_id, r_ptr, w_ptr, w_pick, w_id_inc;
  logic [CNT_W-1:0]       r_cnt, w_cnt;
  logic                   r_wr, w_wr, r_to, w_to, w_found, w_done, w_exp;
  assign w_req = bus.req_rd | bus.req_wr;
  arb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .i_req  (w_req),
    .i_ptr  (r_ptr),
    .o_found(w_found),
    .o_pick (w_pick)
  );
  assign w_done = (r_state == RD) ? (bus.rsp_rvalid & bus.m_rready[r_id])
                                  : ((r_state == WR) & bus.rsp_bvalid & bus.m_bready[r_id]);
  // completion in the final cycle beats the watchdog
  assign w_exp    = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1)) && !w_done;
  assign w_id_inc = (r_id == IW'(NUM_MASTERS - 1)) ? '0 : r_id + 1'b1;
  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_id    = r_id;
    w_wr    = r_wr;
    w_cnt   = r_cnt;
    w_ptr   = r_ptr;
    w_to    = 1'b0;
    if (r_state == IDLE) begin
      if (w_found) begin
        w_state         = bus.req_rd[w_pick] ? RD : WR;
        w_grant         = '0;
        w_grant[w_pick] = 1'b1;
        w_id            = w_pick;
        w_wr            = !bus.req_rd[w_pick];
        w_cnt           = '0;
      end
    end else if (w_done || w_exp) begin
      w_state = IDLE;
      w_grant = '0;
      w_id    = '0;
      w_wr    = 1'b0;
      w_cnt   = '0;
      w_ptr   = w_id_inc;
      w_to    = w_exp;
    end else begin
      w_cnt = (r_cnt == CNT_W'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_id    <= '0;
      r_wr    <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_id    <= w_id;
      r_wr    <= w_wr;
      r_cnt   <= w_cnt;
      r_ptr   <= w_ptr;
      r_to    <= w_to;
    end
  end
  assign bus.grant       = r_grant;
  assign bus.grant_id    = r_id;
  assign bus.grant_wr    = r_wr;
  assign bus.busy        = (r_state != IDLE);
  assign bus.timeout_err = r_to;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random traffic against an owner/age model of the arbiter, including async resets
module tb_mem_bus_arbiter;
  localparam int N  = 2;
  localparam int TO = 4;
  logic clk, rst;
  int checks = 0, failures = 0;
  int m_own, m_age, m_ptr;
  bit m_wr, m_to;
  mem_bus_arbiter_if #(.N(N)) bus ();
  mem_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_own = -1; m_age = 0; m_ptr = 0; m_wr = 0; m_to = 0;
  endtask
  task automatic check_outputs(input string ctx);
    chk({ctx, " grant"}, 32'(bus.grant), (m_own < 0) ? 32'd0 : 32'(1 << m_own));
    chk({ctx, " grant_id"}, 32'(bus.grant_id), (m_own < 0) ? 32'd0 : 32'(m_own));
    chk({ctx, " grant_wr"}, 32'(bus.grant_wr), 32'(m_wr));
    chk({ctx, " busy"}, 32'(bus.busy), 32'(m_own >= 0));
    chk({ctx, " timeout_err"}, 32'(bus.timeout_err), 32'(m_to));
  endtask
  task automatic model_step();
    bit done;
    m_to = 0;
    if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (bus.req_rd[c] || bus.req_wr[c]) begin
          m_own = c; m_wr = !bus.req_rd[c]; m_age = 0;
          break;
        end
      end
    end else begin
      done = m_wr ? (bus.rsp_bvalid && bus.m_bready[m_own]) : (bus.rsp_rvalid && bus.m_rready[m_own]);
      if (done || m_age == TO - 1) begin
        m_to = !done; m_ptr = (m_own + 1) % N; m_own = -1; m_wr = 0;
      end else m_age++;
    end
  endtask
  task automatic drive_random();
    bus.req_rd     = 2'($urandom_range(0, 3));
    bus.req_wr     = 2'($urandom_range(0, 3));
    bus.rsp_rvalid = ($urandom_range(0, 9) < 4);
    bus.m_rready   = 2'($urandom_range(0, 3));
    bus.rsp_bvalid = ($urandom_range(0, 9) < 4);
    bus.m_bready   = 2'($urandom_range(0, 3));
  endtask
  initial begin
    rst = 1'b1;
    bus.req_rd = '0; bus.req_wr = '0; bus.rsp_rvalid = 0; bus.m_rready = '0;
    bus.rsp_bvalid = 0; bus.m_bready = '0;
    model_reset();
    #2 check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    model_step();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check_outputs("run");
      if (m_own >= 0 && $urandom_range(0, 99) < 2) begin
        #1 rst = 1'b1;
        #1 model_reset();
        check_outputs("async_rst");
        #1 rst = 1'b0;
      end
      drive_random();
      model_step();
    end
    @(negedge clk);
    check_outputs("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
